// File: rtl/serial_alu_controller.sv
// ---------------------------------------------------------------------------
// serial_alu_controller
//   Bit-serial ALU. One WIDTH-bit operation is computed LSB first by reusing
//   a single one-bit slice for WIDTH cycles, with the ripple carry held in a
//   flop between cycles. Same opcode set and flag meaning as a full-width
//   ripple ALU.
//
//   Ports
//     clk       : rising-edge clock
//     reset     : synchronous, active-high
//     start     : request, accepted only while ready = 1
//     op        : 000 ADD, 001 SUB, 010 XOR, 011 SLT,
//                 100 AND, 101 NAND, 110 NOR, 111 OR
//     operandA  : first operand, latched on accept
//     operandB  : second operand, latched on accept
//     ready     : high while idle
//     done      : one-cycle pulse, result and flags valid
//     result    : registered result, held until the next done
//     carryout  : carry out of the MSB (ADD/SUB only)
//     overflow  : signed overflow (ADD/SUB only)
//     zero      : result == 0
//
//   bitSliceALU is the one-bit slice driven by the sequencer: a full adder
//   with an optional inversion of b, plus the five bitwise outputs.
// ---------------------------------------------------------------------------

module bitSliceALU (
   input  logic a,
   input  logic b,
   input  logic carryin,
   input  logic invert,
   output logic sum,
   output logic carryout,
   output logic res_and,
   output logic res_nand,
   output logic res_nor,
   output logic res_or,
   output logic res_xor
);

   logic b_eff_s;

   // One-bit adder (b optionally complemented) and bitwise results
   always_comb begin
      b_eff_s  = b ^ invert;
      sum      = a ^ b_eff_s ^ carryin;
      carryout = (a & b_eff_s) | (a & carryin) | (b_eff_s & carryin);
      res_and  = a & b;
      res_nand = ~(a & b);
      res_nor  = ~(a | b);
      res_or   = a | b;
      res_xor  = a ^ b;
   end

endmodule

module serial_alu_controller #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carryout,
   output logic             overflow,
   output logic             zero
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_SLT  = 3'b011;
   localparam logic [2:0] OP_AND  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_NOR  = 3'b110;
   localparam logic [2:0] OP_OR   = 3'b111;

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] ONE  = CW'(32'd1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   // Collected low bits; the newest bit enters at the top, so after the last
   // shift bit 0 of the answer sits at sr_r[0].
   logic [WIDTH-2:0] sr_r;
   logic [2:0]       op_r;
   logic             carry_r;

   logic             accept_s;
   logic             last_bit_s;
   logic             sub_req_s;
   logic             invert_s;
   logic             slice_sum_s;
   logic             slice_cout_s;
   logic             slice_and_s;
   logic             slice_nand_s;
   logic             slice_nor_s;
   logic             slice_or_s;
   logic             slice_xor_s;
   logic             sel_bit_s;
   logic [WIDTH-1:0] sr_cat_s;
   logic             ovf_s;
   logic [WIDTH-1:0] fin_result_s;
   logic             fin_cout_s;
   logic             fin_ovf_s;

   bitSliceALU u_slice (
      .a        (sa_r[0]),
      .b        (sb_r[0]),
      .carryin  (carry_r),
      .invert   (invert_s),
      .sum      (slice_sum_s),
      .carryout (slice_cout_s),
      .res_and  (slice_and_s),
      .res_nand (slice_nand_s),
      .res_nor  (slice_nor_s),
      .res_or   (slice_or_s),
      .res_xor  (slice_xor_s)
   );

   // Next-state logic for the IDLE/RUN/DONE sequencer
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_next_s = RUN;
            end else begin
               state_next_s = IDLE;
            end
         end
         RUN: begin
            if (last_bit_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = RUN;
            end
         end
         DONE:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // Per-bit control, bit selection and final-cycle result/flag formation
   always_comb begin
      accept_s   = (state_r == IDLE) && start;
      last_bit_s = (count_r == LAST);
      sub_req_s  = (op == OP_SUB) || (op == OP_SLT);
      invert_s   = (op_r == OP_SUB) || (op_r == OP_SLT);

      sel_bit_s = 1'b0;
      case (op_r)
         OP_ADD, OP_SUB, OP_SLT: sel_bit_s = slice_sum_s;
         OP_XOR:                 sel_bit_s = slice_xor_s;
         OP_AND:                 sel_bit_s = slice_and_s;
         OP_NAND:                sel_bit_s = slice_nand_s;
         OP_NOR:                 sel_bit_s = slice_nor_s;
         OP_OR:                  sel_bit_s = slice_or_s;
         default:                sel_bit_s = 1'b0;
      endcase

      sr_cat_s = {sel_bit_s, sr_r};
      // Carry into the MSB is the held carry during the final cycle
      ovf_s    = carry_r ^ slice_cout_s;

      fin_result_s = sr_cat_s;
      fin_cout_s   = 1'b0;
      fin_ovf_s    = 1'b0;
      case (op_r)
         OP_ADD, OP_SUB: begin
            fin_result_s = sr_cat_s;
            fin_cout_s   = slice_cout_s;
            fin_ovf_s    = ovf_s;
         end
         OP_SLT: begin
            // Sign of the true difference: sum MSB corrected by overflow
            fin_result_s = {{(WIDTH-1){1'b0}}, slice_sum_s ^ ovf_s};
            fin_cout_s   = 1'b0;
            fin_ovf_s    = 1'b0;
         end
         default: begin
            fin_result_s = sr_cat_s;
            fin_cout_s   = 1'b0;
            fin_ovf_s    = 1'b0;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Operand shift registers, accumulator, carry flop and bit counter
   always_ff @(posedge clk) begin
      if (reset) begin
         sa_r    <= {WIDTH{1'b0}};
         sb_r    <= {WIDTH{1'b0}};
         sr_r    <= {(WIDTH-1){1'b0}};
         op_r    <= 3'b000;
         carry_r <= 1'b0;
         count_r <= {CW{1'b0}};
      end else if (accept_s) begin
         sa_r    <= operandA;
         sb_r    <= operandB;
         sr_r    <= {(WIDTH-1){1'b0}};
         op_r    <= op;
         carry_r <= sub_req_s;
         count_r <= {CW{1'b0}};
      end else if (state_r == RUN) begin
         sa_r    <= {1'b0, sa_r[WIDTH-1:1]};
         sb_r    <= {1'b0, sb_r[WIDTH-1:1]};
         sr_r    <= sr_cat_s[WIDTH-1:1];
         carry_r <= slice_cout_s;
         if (!last_bit_s) begin
            count_r <= count_r + ONE;
         end
      end
   end

   // Registered outputs: handshake every cycle, result/flags on entering DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         ready    <= 1'b1;
         done     <= 1'b0;
         result   <= {WIDTH{1'b0}};
         carryout <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b1;
      end else begin
         ready <= (state_next_s == IDLE);
         done  <= (state_next_s == DONE);
         if ((state_r == RUN) && last_bit_s) begin
            result   <= fin_result_s;
            carryout <= fin_cout_s;
            overflow <= fin_ovf_s;
            zero     <= (fin_result_s == {WIDTH{1'b0}});
         end
      end
   end

endmodule

// File: tb/tb_serial_alu_controller.sv
// ---------------------------------------------------------------------------
// tb_serial_alu_controller
//   Self-checking bench for serial_alu_controller (WIDTH = 32). A cycle-level
//   behavioural model (busy countdown + arithmetic result) is compared with
//   every DUT output on every falling edge; directed sequences add literal
//   expectations and latency checks, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_serial_alu_controller;

   localparam int W = 32;

   logic          clk;
   logic          reset;
   logic          start;
   logic [2:0]    op_i;
   logic [W-1:0]  a_i;
   logic [W-1:0]  b_i;
   logic          ready;
   logic          done;
   logic [W-1:0]  result;
   logic          carryout;
   logic          overflow;
   logic          zero;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   serial_alu_controller #(.WIDTH(W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .op       (op_i),
      .operandA (a_i),
      .operandB (b_i),
      .ready    (ready),
      .done     (done),
      .result   (result),
      .carryout (carryout),
      .overflow (overflow),
      .zero     (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Arithmetic reference: returns {result, carryout, overflow}
   function automatic logic [W+1:0] model_op(input logic [2:0] o, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
      logic [W:0]   s;
      logic [W-1:0] r;
      logic         co;
      logic         ov;
      s = '0; r = '0; co = 1'b0; ov = 1'b0;
      case (o)
         3'd0: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0]; co = s[W];
            ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd1: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[W-1:0]; co = s[W];
            ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         3'd2: r = a ^ b;
         3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      return {r, co, ov};
   endfunction

   // Behavioural model: busy countdown from accept to return to idle
   int           m_busy = 0;
   logic         m_ready, m_done, m_co, m_ov;
   logic [W-1:0] m_res;
   logic [W+1:0] m_pend;

   always @(posedge clk) begin
      if (reset) begin
         m_busy <= 0; m_ready <= 1'b1; m_done <= 1'b0;
         m_res <= '0; m_co <= 1'b0; m_ov <= 1'b0;
      end else if (m_busy == 0) begin
         if (start) begin
            m_busy  <= W + 1;
            m_ready <= 1'b0;
            m_pend  <= model_op(op_i, a_i, b_i);
         end
      end else if (m_busy == 2) begin
         m_busy <= 1;
         m_done <= 1'b1;
         m_res  <= m_pend[W+1:2];
         m_co   <= m_pend[1];
         m_ov   <= m_pend[0];
      end else if (m_busy == 1) begin
         m_busy  <= 0;
         m_done  <= 1'b0;
         m_ready <= 1'b1;
      end else begin
         m_busy <= m_busy - 1;
      end
   end

   // Compare every output with the model on each falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("ready",    {63'd0, ready},    {63'd0, m_ready});
         check("done",     {63'd0, done},     {63'd0, m_done});
         check("result",   {32'd0, result},   {32'd0, m_res});
         check("carryout", {63'd0, carryout}, {63'd0, m_co});
         check("overflow", {63'd0, overflow}, {63'd0, m_ov});
         check("zero",     {63'd0, zero},     {63'd0, (m_res == 32'd0)});
      end
   end

   // Directed op from idle: latency, literal result/flags, ready afterwards
   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic eco, input logic eov,
                         input string nm);
      int n;
      bit got;
      op_i = o; a_i = a; b_i = b; start = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      op_i = 3'($urandom); a_i = $urandom; b_i = $urandom;
      n = 1; got = 1'b0;
      while (!got && n < 100) begin
         @(negedge clk);
         if (done) got = 1'b1;
         else n++;
      end
      check({nm, " latency"},  n,                  33);
      check({nm, " result"},   {32'd0, result},    {32'd0, er});
      check({nm, " carryout"}, {63'd0, carryout},  {63'd0, eco});
      check({nm, " overflow"}, {63'd0, overflow},  {63'd0, eov});
      check({nm, " zero"},     {63'd0, zero},      {63'd0, (er == 32'd0)});
      @(negedge clk);
      check({nm, " ready back"}, {63'd0, ready}, 64'd1);
   endtask

   function automatic logic [W-1:0] pick_operand();
      case ($urandom_range(0, 5))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   int           n;
   int           dcnt;
   int           t0, t1;
   logic [W-1:0] r0, r1;

   initial begin
      reset = 1'b1; start = 1'b0; op_i = 3'd0; a_i = '0; b_i = '0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      check("rst ready",  {63'd0, ready},  64'd1);
      check("rst done",   {63'd0, done},   64'd0);
      check("rst result", {32'd0, result}, 64'd0);
      check("rst zero",   {63'd0, zero},   64'd1);
      chk_en = 1'b1;

      run_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, "add ovf");
      run_op(3'd1, 32'd5,          32'd5,          32'h0000_0000, 1'b1, 1'b0, "sub 5-5");
      run_op(3'd1, 32'd0,          32'd1,          32'hFFFF_FFFF, 1'b0, 1'b0, "sub 0-1");
      run_op(3'd1, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF, 1'b1, 1'b1, "sub min-1");
      run_op(3'd3, 32'hFFFF_FFFF, 32'd1,          32'd1,         1'b0, 1'b0, "slt -1<1");
      run_op(3'd3, 32'h8000_0000, 32'd1,          32'd1,         1'b0, 1'b0, "slt min<1");
      run_op(3'd3, 32'd5,          32'd5,          32'd0,         1'b0, 1'b0, "slt 5<5");
      run_op(3'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, "and");
      run_op(3'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FFF_0FFF, 1'b0, 1'b0, "nand");
      run_op(3'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F, 1'b0, 1'b0, "nor");
      run_op(3'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0, 1'b0, "or");
      run_op(3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0, 1'b0, "xor");

      // start pulsed during bit 5 must be ignored
      op_i = 3'd0; a_i = 32'd1; b_i = 32'd1; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (5) @(posedge clk);
      #2 start = 1'b1; op_i = 3'd1; a_i = 32'h1234_5678; b_i = 32'h0000_0FFF;
      @(posedge clk); #2 start = 1'b0;
      n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      check("ignored start done",   {63'd0, done},   64'd1);
      check("ignored start result", {32'd0, result}, 64'd2);
      repeat (2) @(negedge clk);

      // reset during bit 10 aborts with no done
      op_i = 3'd0; a_i = 32'd100; b_i = 32'd23; start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
      repeat (10) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk); #2 reset = 1'b0;
      @(negedge clk);
      check("abort ready",  {63'd0, ready},  64'd1);
      check("abort done",   {63'd0, done},   64'd0);
      check("abort result", {32'd0, result}, 64'd0);
      check("abort zero",   {63'd0, zero},   64'd1);
      dcnt = 0;
      repeat (40) begin @(negedge clk); if (done) dcnt++; end
      check("abort no done", dcnt, 0);

      // back-to-back with start held high
      op_i = 3'd0; a_i = 32'd3; b_i = 32'd4; start = 1'b1;
      @(posedge clk); #2;
      op_i = 3'd2; a_i = 32'h0000_00FF; b_i = 32'h0000_000F;
      dcnt = 0; n = 0; t0 = 0; t1 = 0; r0 = '0; r1 = '0;
      while (dcnt < 2 && n < 200) begin
         @(negedge clk); n++;
         if (done) begin
            if (dcnt == 0) begin t0 = cyc; r0 = result; end
            else begin t1 = cyc; r1 = result; end
            dcnt++;
         end
      end
      start = 1'b0;
      check("b2b count",  dcnt,          2);
      check("b2b first",  {32'd0, r0},   64'd7);
      check("b2b second", {32'd0, r1},   64'hF0);
      check("b2b gap",    t1 - t0,       34);
      repeat (3) @(negedge clk);

      // randomized traffic, occasional reset, checked by the model
      for (int i = 0; i < 2500; i++) begin
         @(posedge clk); #2;
         start = ($urandom_range(0, 3) == 0);
         op_i  = 3'($urandom);
         a_i   = pick_operand();
         b_i   = pick_operand();
         reset = ($urandom_range(0, 399) == 0);
      end
      @(posedge clk); #2 start = 1'b0; reset = 1'b0;
      repeat (40) @(posedge clk);
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
